// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: op codes, FSM states and field widths.
// Bit 2 of every op code selects the inverted-B adder path (SUB, SLT).
package alu_pkg;

    localparam int OP_WIDTH = 3;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_MUL = 3'b011,
        OP_NOR = 3'b100,
        OP_RSV = 3'b101,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DONE
    } state_e;

endpackage

// File: rtl/multicycle_alu_if.sv
// Operand-issue and writeback handshake bundle for multicycle_alu.
// The master side issues operands and consumes results; the ALU is the slave.
interface multicycle_alu_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
);

    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic [OP_WIDTH-1:0] op;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    result;
    logic [WIDTH-1:0]    result_hi;
    logic                carry;
    logic                overflow;
    logic                zero;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, result_hi, carry, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, result_hi, carry, overflow, zero
    );

endinterface

// File: rtl/alu_datapath.sv
// Single-cycle logic/arithmetic datapath: AND/OR/NOR/ADD/SUB/SLT plus flags.
// MUL is handled by the sequential multiplier in the top level, so it yields zeros here.
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  op_e              op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             zero_o
);

    logic             invertB;
    logic [WIDTH-1:0] bEff;
    logic [WIDTH:0]   sum;
    logic             sumOverflow;

    // One shared adder; SUB and SLT reuse it as a + ~b + 1.
    always_comb begin
        invertB     = op_i[2];
        bEff        = invertB ? ~b_i : b_i;
        sum         = {1'b0, a_i} + {1'b0, bEff} + {{WIDTH{1'b0}}, invertB};
        sumOverflow = (a_i[WIDTH-1] == bEff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
    end

    always_comb begin
        result_o   = '0;
        carry_o    = 1'b0;
        overflow_o = 1'b0;
        unique case (op_i)
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_NOR: result_o = ~(a_i | b_i);
            OP_ADD, OP_SUB: begin
                result_o   = sum[WIDTH-1:0];
                carry_o    = sum[WIDTH];
                overflow_o = sumOverflow;
            end
            OP_SLT: result_o = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ sumOverflow};
            default: result_o = '0;
        endcase
        zero_o = (result_o == '0);
    end

endmodule

// File: rtl/multicycle_alu.sv
// Registered ALU with valid/ready handshakes and a radix-2 shift-add unsigned multiplier.
// Owns the IDLE/MUL/DONE FSM, the multiplier registers and the output registers.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic              clk,
    input logic              reset,
    multicycle_alu_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   accHi_q, accHi_d;
    logic [WIDTH-1:0]   accLo_q, accLo_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   resultHi_q, resultHi_d;
    logic               carry_q, carry_d;
    logic               overflow_q, overflow_d;
    logic               zero_q, zero_d;

    op_e                opIn;
    logic               inReady;
    logic               accept;
    logic [WIDTH-1:0]   dpResult;
    logic               dpCarry;
    logic               dpOverflow;
    logic               dpZero;
    logic [WIDTH:0]     stepSum;
    logic [WIDTH-1:0]   stepHi;
    logic [WIDTH-1:0]   stepLo;

    assign opIn    = op_e'(bus.op);
    assign inReady = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
    assign accept  = bus.in_valid && inReady;

    alu_datapath #(.WIDTH(WIDTH)) u_datapath (
        .a_i        (bus.a),
        .b_i        (bus.b),
        .op_i       (opIn),
        .result_o   (dpResult),
        .carry_o    (dpCarry),
        .overflow_o (dpOverflow),
        .zero_o     (dpZero)
    );

    // {accHi, accLo} is the product register; the multiplier shifts out of accLo.
    always_comb begin
        stepSum = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, mcand_q} : '0);
        stepHi  = stepSum[WIDTH:1];
        stepLo  = {stepSum[0], accLo_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        accHi_d    = accHi_q;
        accLo_d    = accLo_q;
        result_d   = result_q;
        resultHi_d = resultHi_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;

        unique case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_MUL: begin
                accHi_d = stepHi;
                accLo_d = stepLo;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = ST_DONE;
                    result_d   = stepLo;
                    resultHi_d = stepHi;
                    carry_d    = 1'b0;
                    overflow_d = 1'b0;
                    zero_d     = ({stepHi, stepLo} == '0);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An accept overrides the drain to IDLE so back-to-back ops have no bubble.
        if (accept) begin
            if (opIn == OP_MUL) begin
                state_d = ST_MUL;
                mcand_d = bus.a;
                accLo_d = bus.b;
                accHi_d = '0;
                cnt_d   = CNT_W'(WIDTH);
            end else begin
                state_d    = ST_DONE;
                result_d   = dpResult;
                resultHi_d = '0;
                carry_d    = dpCarry;
                overflow_d = dpOverflow;
                zero_d     = dpZero;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mcand_q    <= '0;
            accHi_q    <= '0;
            accLo_q    <= '0;
            result_q   <= '0;
            resultHi_q <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            accHi_q    <= accHi_d;
            accLo_q    <= accLo_d;
            result_q   <= result_d;
            resultHi_q <= resultHi_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = result_q;
    assign bus.result_hi = resultHi_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;

endmodule
